as_sc_hs_ro_meas: RTL and testbench

Ring-oscillator measurement controller for the sky130_as_sc_hs characterization test chip. It shares one edge counter among N on-chip ring oscillators, each built from library cells such as inv, nand2 or nor2 chains behind a per-oscillator prescaler. For each selected oscillator it enables the oscillator, waits a settle interval, counts prescaled edges over a fixed gate window and reports the count. It runs either a single measurement or an automatic scan over all oscillators, and sits between the test-chip register interface and the oscillator array.

---
 rtl/as_sc_hs_ro_pkg.sv | 27 ++
 rtl/as_sc_hs_ro_edge.sv | 34 +++
 rtl/as_sc_hs_ro_meas.sv | 188 ++++++++++++++++++
 tb/tb_as_sc_hs_ro_meas.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/as_sc_hs_ro_pkg.sv
// as_sc_hs_ro_pkg
// Shared definitions for the ring-oscillator measurement controller:
// the controller state encoding, the gate-window length helper and the
// minimum settle interval, together with a helper that checks it.
package as_sc_hs_ro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } ro_state_t;

    // The synchronizer and the previous-value flop hold three samples of
    // the previously selected oscillator. Four settle cycles flush all of
    // them before the window opens.
    localparam int SETTLE_MIN = 4;

    function automatic int win_len(input int win_log2);
        return 1 << win_log2;
    endfunction

    function automatic bit settle_ok(input int settle);
        return settle >= SETTLE_MIN;
    endfunction

endpackage

// File: rtl/as_sc_hs_ro_edge.sv
// as_sc_hs_ro_edge
// Brings one prescaled oscillator output into the CLK domain and flags
// its rising edges.
// Ports:
//   CLK   clock
//   RST   synchronous active-high reset
//   din   asynchronous oscillator output (already muxed)
//   rise  one-cycle pulse per rising edge, two cycles after the input changes
module as_sc_hs_ro_edge (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/as_sc_hs_ro_meas.sv
// as_sc_hs_ro_meas
// Measures the frequency of N_RO ring oscillators with one shared edge
// counter. For each selected oscillator it enables it, waits SETTLE cycles,
// counts prescaled rising edges for 2^WIN_LOG2 cycles and reports the count.
// Either one oscillator (SEL) or all of them in order (SCAN) are measured.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   START           one-cycle request; SCAN and SEL are sampled with it
//   ABORT           cancels any activity, returns to idle without a result
//   RO_DIV          prescaled oscillator outputs (asynchronous)
//   RO_EN           oscillator enables, one-hot or zero
//   BUSY            high while a measurement or scan is in progress
//   RES_VALID       one-cycle result strobe; RES_IDX/RES_COUNT/RES_SAT hold
//   DONE            pulses with the last result of a normal completion
module as_sc_hs_ro_meas
    import as_sc_hs_ro_pkg::*;
#(
    parameter int N_RO     = 8,
    parameter int CNT_W    = 16,
    parameter int WIN_LOG2 = 10,
    parameter int SETTLE   = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic                     SCAN,
    input  logic [$clog2(N_RO)-1:0]  SEL,
    input  logic                     ABORT,
    input  logic [N_RO-1:0]          RO_DIV,
    output logic [N_RO-1:0]          RO_EN,
    output logic                     BUSY,
    output logic                     RES_VALID,
    output logic [$clog2(N_RO)-1:0]  RES_IDX,
    output logic [CNT_W-1:0]         RES_COUNT,
    output logic                     RES_SAT,
    output logic                     DONE
);

    localparam int IW  = $clog2(N_RO);
    localparam int WIN = win_len(WIN_LOG2);
    localparam int TW  = $clog2((WIN > SETTLE) ? WIN : SETTLE) + 1;

    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0]    WIN_LAST    = TW'(WIN - 1);
    localparam logic [IW-1:0]    IDX_LAST    = IW'(N_RO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    if (!settle_ok(SETTLE)) begin : g_settle_chk
        $error("SETTLE must be at least %0d", SETTLE_MIN);
    end
    if (N_RO < 2) begin : g_nro_chk
        $error("N_RO must be at least 2");
    end

    ro_state_t         state;
    logic [IW-1:0]     idx;
    logic              scan_q;
    logic [TW-1:0]     tmr;
    logic [CNT_W-1:0]  cnt;
    logic              sat;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              sat_nxt;
    logic              ro_sel;
    logic              rise;
    logic              sel_ok;
    logic              last_idx;

    function automatic logic [N_RO-1:0] onehot(input logic [IW-1:0] i);
        logic [N_RO-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Only the selected oscillator reaches the synchronizer.
    assign ro_sel = RO_DIV[idx];

    as_sc_hs_ro_edge u_edge (
        .CLK  (CLK),
        .RST  (RST),
        .din  (ro_sel),
        .rise (rise)
    );

    assign sel_ok   = int'(SEL) < N_RO;
    assign last_idx = !scan_q || (idx == IDX_LAST);

    // Saturating count including an edge in the current cycle; used both to
    // update the counter and to capture the final result at window close.
    // Saturation is flagged when an edge arrives with the counter at max.
    always_comb begin
        cnt_nxt = cnt;
        sat_nxt = sat;
        if (rise) begin
            if (cnt == CNT_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            idx       <= '0;
            scan_q    <= 1'b0;
            tmr       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            RO_EN     <= '0;
            BUSY      <= 1'b0;
            RES_VALID <= 1'b0;
            RES_IDX   <= '0;
            RES_COUNT <= '0;
            RES_SAT   <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            RES_VALID <= 1'b0;
            DONE      <= 1'b0;
            if (ABORT) begin
                state <= ST_IDLE;
                RO_EN <= '0;
                BUSY  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (START && (SCAN || sel_ok)) begin
                            state  <= ST_SETTLE;
                            idx    <= SCAN ? '0 : SEL;
                            scan_q <= SCAN;
                            tmr    <= '0;
                            cnt    <= '0;
                            sat    <= 1'b0;
                            RO_EN  <= onehot(SCAN ? '0 : SEL);
                            BUSY   <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (tmr == SETTLE_LAST) begin
                            tmr   <= '0;
                            state <= ST_MEASURE;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        cnt <= cnt_nxt;
                        sat <= sat_nxt;
                        if (tmr == WIN_LAST) begin
                            // Outputs are registered, so the report is
                            // loaded on the transition into REPORT.
                            tmr       <= '0;
                            state     <= ST_REPORT;
                            RES_VALID <= 1'b1;
                            RES_IDX   <= idx;
                            RES_COUNT <= cnt_nxt;
                            RES_SAT   <= sat_nxt;
                            DONE      <= last_idx;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    ST_REPORT: begin
                        if (!last_idx) begin
                            state <= ST_SETTLE;
                            idx   <= idx + 1'b1;
                            tmr   <= '0;
                            cnt   <= '0;
                            sat   <= 1'b0;
                            RO_EN <= onehot(idx + 1'b1);
                        end else begin
                            state <= ST_IDLE;
                            RO_EN <= '0;
                            BUSY  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        RO_EN <= '0;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_as_sc_hs_ro_meas.sv
// Directed bench for as_sc_hs_ro_meas. The main instance uses N_RO=4,
// WIN_LOG2=4, SETTLE=4 (result 21 cycles after START). A second instance
// with N_RO=5 and CNT_W=2 covers counter saturation and an out-of-range SEL.
// Oscillators are square waves derived from a free-running cycle counter:
// psel=1 gives period 4, 2 gives period 8, 3 gives period 16.
module tb_as_sc_hs_ro_meas;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        SCAN = 1'b0;
    logic [1:0]  SEL = '0;
    logic        ABORT = 1'b0;
    logic [3:0]  RO_DIV;
    logic [3:0]  RO_EN;
    logic        BUSY;
    logic        RES_VALID;
    logic [1:0]  RES_IDX;
    logic [15:0] RES_COUNT;
    logic        RES_SAT;
    logic        DONE;

    logic        start2 = 1'b0;
    logic [2:0]  sel2 = '0;
    logic [4:0]  ro_div2;
    logic [4:0]  ro_en2;
    logic        busy2;
    logic        res_valid2;
    logic [2:0]  res_idx2;
    logic [1:0]  res_count2;
    logic        res_sat2;
    logic        done2;

    logic [31:0] cyc = '0;
    int          psel [4];
    int          errors = 0;
    int          checks = 0;

    always #5 CLK = ~CLK;
    always @(negedge CLK) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < 4; i++) RO_DIV[i] = cyc[psel[i]];
        ro_div2 = {cyc[1], RO_DIV};
    end

    as_sc_hs_ro_meas #(.N_RO(4), .CNT_W(16), .WIN_LOG2(4), .SETTLE(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SCAN(SCAN), .SEL(SEL),
        .ABORT(ABORT), .RO_DIV(RO_DIV), .RO_EN(RO_EN), .BUSY(BUSY),
        .RES_VALID(RES_VALID), .RES_IDX(RES_IDX), .RES_COUNT(RES_COUNT),
        .RES_SAT(RES_SAT), .DONE(DONE)
    );

    as_sc_hs_ro_meas #(.N_RO(5), .CNT_W(2), .WIN_LOG2(4), .SETTLE(4)) dut2 (
        .CLK(CLK), .RST(RST), .START(start2), .SCAN(SCAN), .SEL(sel2),
        .ABORT(ABORT), .RO_DIV(ro_div2), .RO_EN(ro_en2), .BUSY(busy2),
        .RES_VALID(res_valid2), .RES_IDX(res_idx2), .RES_COUNT(res_count2),
        .RES_SAT(res_sat2), .DONE(done2)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_cnt [4];
        logic seen;
        exp_cnt = '{4, 2, 1, 4};
        psel = '{1, 2, 1, 1};

        // Reset state
        step(); step();
        RST = 1'b0;
        chk("rst_ro_en", 32'(RO_EN), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_valid", 32'(RES_VALID), 0);
        chk("rst_idx", 32'(RES_IDX), 0);
        chk("rst_count", 32'(RES_COUNT), 0);
        chk("rst_sat", 32'(RES_SAT), 0);
        chk("rst_done", 32'(DONE), 0);

        // Single measurement of index 2 (period 4); dut2 saturates at 3
        SEL = 2'd2; sel2 = 3'd2; START = 1'b1; start2 = 1'b1;
        step();
        START = 1'b0; start2 = 1'b0;
        chk("single_busy_t1", 32'(BUSY), 1);
        chk("single_ro_en_t1", 32'(RO_EN), 32'h4);
        START = 1'b1; SEL = 2'd1;
        step();
        START = 1'b0;
        chk("start_while_busy_ro_en", 32'(RO_EN), 32'h4);
        chk("start_while_busy_busy", 32'(BUSY), 1);
        repeat (18) step();
        chk("single_no_valid_t20", 32'(RES_VALID), 0);
        chk("single_ro_en_t20", 32'(RO_EN), 32'h4);
        step();
        chk("single_valid", 32'(RES_VALID), 1);
        chk("single_idx", 32'(RES_IDX), 2);
        chk("single_count", 32'(RES_COUNT), 4);
        chk("single_sat", 32'(RES_SAT), 0);
        chk("single_done", 32'(DONE), 1);
        chk("single_ro_en_t21", 32'(RO_EN), 32'h4);
        chk("sat_valid", 32'(res_valid2), 1);
        chk("sat_idx", 32'(res_idx2), 2);
        chk("sat_count", 32'(res_count2), 3);
        chk("sat_flag", 32'(res_sat2), 1);
        chk("sat_done", 32'(done2), 1);
        step();
        chk("single_busy_t22", 32'(BUSY), 0);
        chk("single_ro_en_t22", 32'(RO_EN), 0);
        chk("single_valid_t22", 32'(RES_VALID), 0);
        chk("single_done_t22", 32'(DONE), 0);
        chk("single_count_hold", 32'(RES_COUNT), 4);

        // Out-of-range SEL on the 5-oscillator instance is ignored
        sel2 = 3'd5; start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("sel5_busy", 32'(busy2), 0);
        chk("sel5_ro_en", 32'(ro_en2), 0);

        // ABORT wins over START in IDLE
        SEL = 2'd0; START = 1'b1; ABORT = 1'b1;
        step();
        START = 1'b0; ABORT = 1'b0;
        chk("abort_start_busy", 32'(BUSY), 0);
        chk("abort_start_ro_en", 32'(RO_EN), 0);

        // Scan with periods 4, 8, 16, 4
        psel[2] = 3;
        SCAN = 1'b1; START = 1'b1;
        step();
        START = 1'b0; SCAN = 1'b0;
        chk("scan_ro_en_first", 32'(RO_EN), 32'h1);
        for (int k = 0; k < 4; k++) begin
            repeat (20) step();
            chk($sformatf("scan%0d_valid", k), 32'(RES_VALID), 1);
            chk($sformatf("scan%0d_idx", k), 32'(RES_IDX), 32'(k));
            chk($sformatf("scan%0d_count", k), 32'(RES_COUNT), 32'(exp_cnt[k]));
            chk($sformatf("scan%0d_done", k), 32'(DONE), (k == 3) ? 1 : 0);
            if (k < 3) begin
                step();
                chk($sformatf("scan%0d_next_ro_en", k), 32'(RO_EN), 32'(1 << (k + 1)));
                chk($sformatf("scan%0d_valid_gap", k), 32'(RES_VALID), 0);
            end
        end
        step();
        chk("scan_busy_end", 32'(BUSY), 0);

        // ABORT during MEASURE
        SEL = 2'd1; START = 1'b1;
        step();
        START = 1'b0;
        repeat (7) step();
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("abort_ro_en", 32'(RO_EN), 0);
        chk("abort_busy", 32'(BUSY), 0);
        seen = 1'b0;
        repeat (20) begin
            step();
            if (RES_VALID || DONE) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 0);
        chk("abort_idx_kept", 32'(RES_IDX), 3);
        chk("abort_count_kept", 32'(RES_COUNT), 4);

        // Normal run after abort
        SEL = 2'd3; START = 1'b1;
        step();
        START = 1'b0;
        repeat (20) step();
        chk("rerun_valid", 32'(RES_VALID), 1);
        chk("rerun_idx", 32'(RES_IDX), 3);
        chk("rerun_count", 32'(RES_COUNT), 4);
        chk("rerun_done", 32'(DONE), 1);
        step();

        // RST during SETTLE
        SEL = 2'd2; START = 1'b1;
        step();
        START = 1'b0;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("midrst_ro_en", 32'(RO_EN), 0);
        chk("midrst_busy", 32'(BUSY), 0);
        chk("midrst_valid", 32'(RES_VALID), 0);
        chk("midrst_idx", 32'(RES_IDX), 0);
        chk("midrst_count", 32'(RES_COUNT), 0);
        chk("midrst_sat", 32'(RES_SAT), 0);
        chk("midrst_done", 32'(DONE), 0);
        chk("midrst_count2", 32'(res_count2), 0);
        chk("midrst_sat2", 32'(res_sat2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
